text_writer: RTL

Byte-stream text console writer sitting directly upstream of the colour text display's character buffer. Consumes character/control bytes over a valid/ready handshake and drives the buffer's write port (address, {attribute, char} data, clock enable). It tracks a cursor, interprets a small set of control codes, and performs a full-buffer clear. Runs in the pixel clock domain so it shares the buffer's A-port clock.

---
 rtl/text_writer_if.sv | 22 ++
 rtl/text_writer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/text_writer_if.sv
// Byte-stream and character-buffer write-port bundle for text_writer.
interface text_writer_if;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [10:0] o_ada;
  logic [15:0] o_din;
  logic        o_cea;
  logic [5:0]  o_cursor_x;
  logic [4:0]  o_cursor_y;
  logic        o_busy;

  modport master (
    output i_data, i_valid,
    input  o_ready, o_ada, o_din, o_cea, o_cursor_x, o_cursor_y, o_busy
  );

  modport slave (
    input  i_data, i_valid,
    output o_ready, o_ada, o_din, o_cea, o_cursor_x, o_cursor_y, o_busy
  );
endinterface

// File: rtl/text_writer.sv
// Text console writer: cursor tracking, control codes and full-buffer clear.
// Optional attribute escape (0x1B, attr) enabled by defining TEXT_WRITER_ESC_EN.
module text_writer #(
  parameter int unsigned COLS     = 60,
  parameter int unsigned ROWS     = 17,
  parameter logic [7:0]  CLR_CHAR = 8'h20,
  parameter logic [7:0]  DEF_ATTR = 8'h07
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  text_writer_if.slave  bus
);

  localparam int unsigned XW = 6;
  localparam int unsigned YW = 5;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  localparam logic [XW-1:0] X_LAST   = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(ROWS - 1);
  localparam logic [AW-1:0] CNT_LAST = '1;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
`ifdef TEXT_WRITER_ESC_EN
  localparam logic [7:0] CH_ESC = 8'h1B;
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, ESC_WAIT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1} state_e;
`endif

  state_e state_q, state_d;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]    attr_q, attr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          cea_q, cea_d;
  logic [AW-1:0] ada_q, ada_d;
  logic [DW-1:0] din_q, din_d;

  logic          accept;
  logic [YW-1:0] y_inc;

  // ready mirrors "not clearing", so it never depends on i_valid
  assign accept = bus.i_valid & ready_q;
  assign y_inc  = (y_q == Y_LAST) ? '0 : y_q + YW'(1);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.i_data == CH_FF) state_d = CLEAR;
`ifdef TEXT_WRITER_ESC_EN
          else if (bus.i_data == CH_ESC) state_d = ESC_WAIT;
`endif
        end
      end
      CLEAR: begin
        if (done_q) state_d = IDLE;
      end
`ifdef TEXT_WRITER_ESC_EN
      ESC_WAIT: begin
        if (accept) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    attr_d = attr_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    cea_d  = 1'b0;
    ada_d  = ada_q;
    din_d  = din_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.i_data)
            CH_CR: x_d = '0;
            CH_LF: begin
              x_d = '0;
              y_d = y_inc;
            end
            CH_BS: begin
              if (x_q != '0) x_d = x_q - XW'(1);
            end
            CH_FF: begin
              // cell 0 is written on the accepting edge; counter holds the next cell
              cea_d  = 1'b1;
              ada_d  = '0;
              din_d  = {attr_q, CLR_CHAR};
              cnt_d  = AW'(1);
              done_d = 1'b0;
            end
`ifdef TEXT_WRITER_ESC_EN
            CH_ESC: ;
`endif
            default: begin
              cea_d = 1'b1;
              ada_d = {y_q, x_q};
              din_d = {attr_q, bus.i_data};
              if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_inc;
              end else begin
                x_d = x_q + XW'(1);
              end
            end
          endcase
        end
      end
      CLEAR: begin
        if (done_q) begin
          x_d = '0;
          y_d = '0;
        end else begin
          cea_d = 1'b1;
          ada_d = cnt_q;
          din_d = {attr_q, CLR_CHAR};
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == CNT_LAST) done_d = 1'b1;
        end
      end
`ifdef TEXT_WRITER_ESC_EN
      ESC_WAIT: begin
        if (accept) attr_d = bus.i_data;
      end
`endif
      default: ;
    endcase
    ready_d = (state_d != CLEAR);
    busy_d  = (state_d == CLEAR);
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      attr_q  <= DEF_ATTR;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      cea_q   <= 1'b0;
      ada_q   <= '0;
      din_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      attr_q  <= attr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      cea_q   <= cea_d;
      ada_q   <= ada_d;
      din_q   <= din_d;
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_cea      = cea_q;
  assign bus.o_ada      = ada_q;
  assign bus.o_din      = din_q;
  assign bus.o_cursor_x = x_q;
  assign bus.o_cursor_y = y_q;

endmodule
